// File: rtl/unified_mem_pkg.sv
// Shared definitions for the unified instruction/data memory controller.
// Provides the access-width encodings, the region identifier, the decoded
// request and response-context records, and helper functions for region
// placement, access legality, byte-lane masks and read-data extraction.
package unified_mem_pkg;

    // Access sizes in bytes as carried on the *_write_width ports.
    localparam logic [3:0] WIDTH_BYTE = 4'd1;
    localparam logic [3:0] WIDTH_HALF = 4'd2;
    localparam logic [3:0] WIDTH_WORD = 4'd4;

    typedef enum logic [1:0] {
        REGION_INST = 2'd0,
        REGION_DATA = 2'd1,
        REGION_NONE = 2'd2
    } region_e;

    // Round-robin pointer value: which master wins the next same-region conflict.
    typedef enum logic {
        PRI_INST = 1'b0,
        PRI_DATA = 1'b1
    } rr_pri_e;

    // One master's request after address/width decode.
    typedef struct packed {
        logic        fault;
        region_e     region;
        logic        write;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [29:0] word_idx;
        logic [1:0]  offset;
        logic [3:0]  width;
    } req_dec_t;

    // Information captured at acceptance and needed to form the response.
    typedef struct packed {
        logic        valid;
        logic        fault;
        logic        write;
        region_e     src;
        logic [1:0]  offset;
        logic [3:0]  width;
    } resp_ctx_t;

    // First byte address of a region.
    function automatic logic [32:0] region_base(input region_e region,
                                                input int unsigned inst_words);
        case (region)
            REGION_INST: region_base = 33'd0;
            REGION_DATA: region_base = 33'(inst_words) << 2;
            default:     region_base = 33'd0;
        endcase
    endfunction

    // Size of a region in bytes.
    function automatic logic [32:0] region_size(input region_e region,
                                                input int unsigned inst_words,
                                                input int unsigned data_words);
        case (region)
            REGION_INST: region_size = 33'(inst_words) << 2;
            REGION_DATA: region_size = 33'(data_words) << 2;
            default:     region_size = 33'd0;
        endcase
    endfunction

    function automatic logic width_legal(input logic [3:0] width);
        case (width)
            WIDTH_BYTE, WIDTH_HALF, WIDTH_WORD: width_legal = 1'b1;
            default:                            width_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] width, input logic [1:0] offset);
        case (width)
            WIDTH_HALF: misaligned = offset[0];
            WIDTH_WORD: misaligned = (offset != 2'd0);
            default:    misaligned = 1'b0;
        endcase
    endfunction

    // Byte lanes covered by an access of the given width starting at lane 0.
    function automatic logic [3:0] lane_mask(input logic [3:0] width);
        case (width)
            WIDTH_BYTE: lane_mask = 4'b0001;
            WIDTH_HALF: lane_mask = 4'b0011;
            WIDTH_WORD: lane_mask = 4'b1111;
            default:    lane_mask = 4'b0000;
        endcase
    endfunction

    // Move the addressed bytes of a bank word down to bit 0 and zero-extend.
    function automatic logic [31:0] extract_read(input logic [31:0] word,
                                                 input logic [1:0]  offset,
                                                 input logic [3:0]  width);
        logic [31:0] shifted;
        shifted = word >> {offset, 3'b000};
        case (width)
            WIDTH_BYTE: extract_read = shifted & 32'h0000_00FF;
            WIDTH_HALF: extract_read = shifted & 32'h0000_FFFF;
            WIDTH_WORD: extract_read = shifted;
            default:    extract_read = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/unified_memory_ctrl_mem_bank.sv
// mem_bank: single-port 32-bit memory with byte-enable writes and a
// synchronous, registered read.
//   clk_i    : clock (rising edge)
//   en_i     : access strobe
//   we_i     : 1 = write, 0 = read
//   be_i     : byte enables for writes
//   addr_i   : word address
//   wdata_i  : write data, already placed in its byte lanes
//   rdata_o  : read data, valid the cycle after a read; held otherwise
// Contents and the read register are deliberately not reset.
module mem_bank #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Storage array and registered read port.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    // Read data straight from the read register.
    always_comb begin
        rdata_o = rdata_q;
    end

endmodule

// File: rtl/unified_memory_ctrl.sv
// unified_memory_ctrl: two-master (fetch "i", data "d") controller in front of
// an instruction bank (bytes 0 .. INST_SIZE_IN_WORD*4-1) and a data bank
// (following directly).  Either master may address either bank; accesses to
// different banks proceed in parallel, same-bank conflicts are resolved by a
// one-bit round-robin pointer that starts out favouring the data master.
// Ports (per master x in {i, d}):
//   x_req_valid/x_req_ready  : request handshake, ready is combinational
//   x_addr, x_write_enable, x_write_width, x_write_data : request payload
//   x_resp_valid/x_resp_data/x_resp_fault : response, one cycle after accept
// clk is the only clock; reset is synchronous and active high.
module unified_memory_ctrl
    import unified_mem_pkg::*;
#(
    parameter int unsigned INST_SIZE_IN_WORD  = 4096,
    parameter int unsigned DATA_SIZE_IN_WORD  = 4096,
    parameter bit          INST_WRITE_PROTECT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic        d_req_valid,
    output logic        i_req_ready,
    output logic        d_req_ready,
    input  logic [31:0] i_addr,
    input  logic [31:0] d_addr,
    input  logic        i_write_enable,
    input  logic        d_write_enable,
    input  logic [3:0]  i_write_width,
    input  logic [3:0]  d_write_width,
    input  logic [31:0] i_write_data,
    input  logic [31:0] d_write_data,
    output logic        i_resp_valid,
    output logic        d_resp_valid,
    output logic [31:0] i_resp_data,
    output logic [31:0] d_resp_data,
    output logic        i_resp_fault,
    output logic        d_resp_fault
);

    localparam logic [32:0] INST_BASE = region_base(REGION_INST, INST_SIZE_IN_WORD);
    localparam logic [32:0] INST_END  = INST_BASE +
        region_size(REGION_INST, INST_SIZE_IN_WORD, DATA_SIZE_IN_WORD);
    localparam logic [32:0] DATA_BASE = region_base(REGION_DATA, INST_SIZE_IN_WORD);
    localparam logic [32:0] DATA_END  = DATA_BASE +
        region_size(REGION_DATA, INST_SIZE_IN_WORD, DATA_SIZE_IN_WORD);
    localparam int unsigned INST_AW = (INST_SIZE_IN_WORD > 1) ? $clog2(INST_SIZE_IN_WORD) : 1;
    localparam int unsigned DATA_AW = (DATA_SIZE_IN_WORD > 1) ? $clog2(DATA_SIZE_IN_WORD) : 1;

    // Region lookup, legality checks and write-lane placement for one request.
    // A faulting request gets no byte enables so it can never touch a bank.
    function automatic req_dec_t decode_req(input logic [31:0] addr,
                                            input logic        write,
                                            input logic [3:0]  width,
                                            input logic [31:0] wdata);
        req_dec_t dec;
        dec.write  = write;
        dec.width  = width;
        dec.offset = addr[1:0];
        dec.wdata  = wdata << {addr[1:0], 3'b000};
        if ({1'b0, addr} < INST_END) begin
            dec.region   = REGION_INST;
            dec.word_idx = addr[31:2] - INST_BASE[31:2];
        end else if ({1'b0, addr} < DATA_END) begin
            dec.region   = REGION_DATA;
            dec.word_idx = addr[31:2] - DATA_BASE[31:2];
        end else begin
            dec.region   = REGION_NONE;
            dec.word_idx = 30'd0;
        end
        dec.fault = (dec.region == REGION_NONE) | ~width_legal(width) |
                    misaligned(width, addr[1:0]) |
                    ((dec.region == REGION_INST) & write & INST_WRITE_PROTECT);
        dec.be = dec.fault ? 4'b0000 : (lane_mask(width) << addr[1:0]);
        return dec;
    endfunction

    req_dec_t    i_dec_s, d_dec_s;
    logic        conflict_s, d_wins_s;
    logic        i_go_s, d_go_s;
    rr_pri_e     rr_q, rr_d;
    resp_ctx_t   i_ctx_q, i_ctx_d, d_ctx_q, d_ctx_d;
    logic [31:0] i_last_q, d_last_q, i_data_now_s, d_data_now_s;

    logic               ib_en_s, ib_we_s, db_en_s, db_we_s;
    logic [3:0]         ib_be_s, db_be_s;
    logic [INST_AW-1:0] ib_addr_s;
    logic [DATA_AW-1:0] db_addr_s;
    logic [31:0]        ib_wdata_s, db_wdata_s, ib_rdata_s, db_rdata_s;
    logic               unused_s;

    // Decode both masters' requests.
    always_comb begin
        i_dec_s = decode_req(i_addr, i_write_enable, i_write_width, i_write_data);
        d_dec_s = decode_req(d_addr, d_write_enable, d_write_width, d_write_data);
    end

    // Arbitration: only two legal requests to the same bank conflict; faulting
    // requests never occupy a bank and are therefore always ready.
    always_comb begin
        conflict_s = i_req_valid & d_req_valid & ~i_dec_s.fault & ~d_dec_s.fault &
                     (i_dec_s.region == d_dec_s.region);
        d_wins_s   = (rr_q == PRI_DATA);
        if (reset) begin
            i_req_ready = 1'b0;
            d_req_ready = 1'b0;
        end else begin
            i_req_ready = i_req_valid & (~conflict_s | ~d_wins_s);
            d_req_ready = d_req_valid & (~conflict_s | d_wins_s);
        end
        i_go_s = i_req_ready & ~i_dec_s.fault;
        d_go_s = d_req_ready & ~d_dec_s.fault;
        // After a conflict the pointer moves to the master that just lost.
        if (conflict_s && !reset) begin
            rr_d = d_wins_s ? PRI_INST : PRI_DATA;
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= PRI_DATA;
        end else begin
            rr_q <= rr_d;
        end
    end

    // Instruction bank port: steered to whichever master was granted it.
    always_comb begin
        ib_en_s    = 1'b0;
        ib_we_s    = 1'b0;
        ib_be_s    = 4'b0000;
        ib_addr_s  = '0;
        ib_wdata_s = 32'h0000_0000;
        if (d_go_s && (d_dec_s.region == REGION_INST)) begin
            ib_en_s    = 1'b1;
            ib_we_s    = d_dec_s.write;
            ib_be_s    = d_dec_s.be;
            ib_addr_s  = d_dec_s.word_idx[INST_AW-1:0];
            ib_wdata_s = d_dec_s.wdata;
        end else if (i_go_s && (i_dec_s.region == REGION_INST)) begin
            ib_en_s    = 1'b1;
            ib_we_s    = i_dec_s.write;
            ib_be_s    = i_dec_s.be;
            ib_addr_s  = i_dec_s.word_idx[INST_AW-1:0];
            ib_wdata_s = i_dec_s.wdata;
        end else begin
            ib_en_s = 1'b0;
        end
    end

    // Data bank port: steered to whichever master was granted it.
    always_comb begin
        db_en_s    = 1'b0;
        db_we_s    = 1'b0;
        db_be_s    = 4'b0000;
        db_addr_s  = '0;
        db_wdata_s = 32'h0000_0000;
        if (d_go_s && (d_dec_s.region == REGION_DATA)) begin
            db_en_s    = 1'b1;
            db_we_s    = d_dec_s.write;
            db_be_s    = d_dec_s.be;
            db_addr_s  = d_dec_s.word_idx[DATA_AW-1:0];
            db_wdata_s = d_dec_s.wdata;
        end else if (i_go_s && (i_dec_s.region == REGION_DATA)) begin
            db_en_s    = 1'b1;
            db_we_s    = i_dec_s.write;
            db_be_s    = i_dec_s.be;
            db_addr_s  = i_dec_s.word_idx[DATA_AW-1:0];
            db_wdata_s = i_dec_s.wdata;
        end else begin
            db_en_s = 1'b0;
        end
    end

    mem_bank #(
        .DEPTH   (INST_SIZE_IN_WORD),
        .AW      (INST_AW)
    ) u_inst_bank (
        .clk_i   (clk),
        .en_i    (ib_en_s),
        .we_i    (ib_we_s),
        .be_i    (ib_be_s),
        .addr_i  (ib_addr_s),
        .wdata_i (ib_wdata_s),
        .rdata_o (ib_rdata_s)
    );

    mem_bank #(
        .DEPTH   (DATA_SIZE_IN_WORD),
        .AW      (DATA_AW)
    ) u_data_bank (
        .clk_i   (clk),
        .en_i    (db_en_s),
        .we_i    (db_we_s),
        .be_i    (db_be_s),
        .addr_i  (db_addr_s),
        .wdata_i (db_wdata_s),
        .rdata_o (db_rdata_s)
    );

    // Response context capture; fault/shape fields hold when nothing is accepted.
    always_comb begin
        i_ctx_d       = i_ctx_q;
        i_ctx_d.valid = i_req_ready;
        if (i_req_ready) begin
            i_ctx_d.fault  = i_dec_s.fault;
            i_ctx_d.write  = i_dec_s.write;
            i_ctx_d.src    = i_dec_s.region;
            i_ctx_d.offset = i_dec_s.offset;
            i_ctx_d.width  = i_dec_s.width;
        end else begin
            i_ctx_d.fault  = i_ctx_q.fault;
        end
        d_ctx_d       = d_ctx_q;
        d_ctx_d.valid = d_req_ready;
        if (d_req_ready) begin
            d_ctx_d.fault  = d_dec_s.fault;
            d_ctx_d.write  = d_dec_s.write;
            d_ctx_d.src    = d_dec_s.region;
            d_ctx_d.offset = d_dec_s.offset;
            d_ctx_d.width  = d_dec_s.width;
        end else begin
            d_ctx_d.fault  = d_ctx_q.fault;
        end
    end

    // Response data: bank output during the response cycle, otherwise the
    // last value shown.  Writes and faults answer with zero.
    always_comb begin
        if (!i_ctx_q.valid) begin
            i_data_now_s = i_last_q;
        end else if (i_ctx_q.fault || i_ctx_q.write) begin
            i_data_now_s = 32'h0000_0000;
        end else begin
            i_data_now_s = extract_read((i_ctx_q.src == REGION_DATA) ? db_rdata_s : ib_rdata_s,
                                        i_ctx_q.offset, i_ctx_q.width);
        end
        if (!d_ctx_q.valid) begin
            d_data_now_s = d_last_q;
        end else if (d_ctx_q.fault || d_ctx_q.write) begin
            d_data_now_s = 32'h0000_0000;
        end else begin
            d_data_now_s = extract_read((d_ctx_q.src == REGION_DATA) ? db_rdata_s : ib_rdata_s,
                                        d_ctx_q.offset, d_ctx_q.width);
        end
    end

    // Response context and held-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            i_ctx_q  <= '0;
            d_ctx_q  <= '0;
            i_last_q <= 32'h0000_0000;
            d_last_q <= 32'h0000_0000;
        end else begin
            i_ctx_q  <= i_ctx_d;
            d_ctx_q  <= d_ctx_d;
            i_last_q <= i_data_now_s;
            d_last_q <= d_data_now_s;
        end
    end

    // Outputs; reset masks them immediately so a response accepted just
    // before reset rises is never presented.
    always_comb begin
        if (reset) begin
            i_resp_valid = 1'b0;
            d_resp_valid = 1'b0;
            i_resp_data  = 32'h0000_0000;
            d_resp_data  = 32'h0000_0000;
            i_resp_fault = 1'b0;
            d_resp_fault = 1'b0;
        end else begin
            i_resp_valid = i_ctx_q.valid;
            d_resp_valid = d_ctx_q.valid;
            i_resp_data  = i_data_now_s;
            d_resp_data  = d_data_now_s;
            i_resp_fault = i_ctx_q.fault;
            d_resp_fault = d_ctx_q.fault;
        end
    end

    // Word-index bits above the bank address width are not needed.
    always_comb begin
        unused_s = ^{i_dec_s.word_idx, d_dec_s.word_idx};
    end

endmodule
